// File: rtl/aes_enc_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_enc_req_arbiter
// Function : Round-robin sequencer sharing one AES-256 encrypt core among
//            NUM_REQ requesters, with a watchdog that resets a hung core.
// Revision : 1.0
// ============================================================================
module aes_enc_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*128-1:0]   req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic                     rsp_err,
    output logic [127:0]             rsp_data,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [127:0]             core_dataIn,
    output logic                     core_start,
    input  logic                     core_done,
    input  logic [127:0]             core_dataOut,
    output logic                     core_rst_n,
    output logic                     busy
);
    localparam int                 PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]     c_NUM_REQ = (PTR_W+1)'(NUM_REQ);
    localparam logic [CNT_W-1:0]   c_TIMEOUT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BUSY  = 3'd2,
        S_RESP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [127:0]       r_core_data;
    logic [127:0]       r_rsp_data;
    logic               r_rsp_err;
    logic [CNT_W-1:0]   r_wd;

    logic               w_hi_any;
    logic               w_lo_any;
    logic [PTR_W-1:0]   w_hi_sel;
    logic [PTR_W-1:0]   w_lo_sel;
    logic [PTR_W-1:0]   w_sel;
    logic [PTR_W:0]     w_inc;
    logic [127:0]       w_sel_data;
    logic [NUM_REQ-1:0] w_sel_oh;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic               w_accept;
    logic               w_abort;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_hi_any   = 1'b0;
        w_lo_any   = 1'b0;
        w_hi_sel   = '0;
        w_lo_sel   = '0;
        w_sel_data = '0;
        w_sel_oh   = '0;
        w_owner_oh = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                w_lo_any = 1'b1;
                w_lo_sel = PTR_W'(k);
            end
            if (req_valid[k] && (PTR_W'(k) >= r_rr_ptr)) begin
                w_hi_any = 1'b1;
                w_hi_sel = PTR_W'(k);
            end
        end
        w_sel = w_hi_any ? w_hi_sel : w_lo_sel;
        w_inc = {1'b0, w_sel} + (PTR_W+1)'(1);
        if (w_inc >= c_NUM_REQ) begin
            w_inc = '0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_sel == PTR_W'(k)) begin
                w_sel_data = req_data[k*128 +: 128];
            end
            w_sel_oh[k]   = (w_sel == PTR_W'(k));
            w_owner_oh[k] = (r_owner == PTR_W'(k));
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_lo_any) begin
                    w_accept = 1'b1;
                    w_next   = S_START;
                end
            end
            S_START: w_next = S_BUSY;
            S_BUSY: begin
                // A done arriving on the timeout cycle still counts as a good result.
                if (core_done) begin
                    w_next = S_RESP;
                end else if (r_wd == c_TIMEOUT) begin
                    w_abort = 1'b1;
                    w_next  = S_RESP;
                end
            end
            S_RESP: begin
                if (|(rsp_ready & w_owner_oh)) begin
                    w_next = S_GAP;
                end
            end
            S_GAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_core_data <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_wd        <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_core_data <= w_sel_data;
                r_owner     <= w_sel;
                r_rr_ptr    <= w_inc[PTR_W-1:0];
            end
            if (r_state == S_START) begin
                r_wd <= '0;
            end else if (r_state == S_BUSY) begin
                r_wd <= r_wd + CNT_W'(1);
            end
            if ((r_state == S_BUSY) && core_done) begin
                r_rsp_data <= core_dataOut;
                r_rsp_err  <= 1'b0;
            end else if (w_abort) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
            end
        end
    end

    assign req_ready   = w_accept ? w_sel_oh : '0;
    assign rsp_valid   = (r_state == S_RESP) ? w_owner_oh : '0;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign core_dataIn = r_core_data;
    assign core_start  = (r_state == S_START);
    assign core_rst_n  = ~w_abort;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
